// File: rtl/pixel_write_unit.sv
// Pixel write unit: clips shader pixels, packs RGBA8888, computes framebuffer addresses,
// buffers them in a FIFO and issues single-beat writes over a valid/ready port.
module pixel_write_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int VEC_SIZE   = 4,
    parameter int CORD_WIDTH = 10,
    parameter int ADDR_WIDTH = 32,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE = ADDR_WIDTH'(32'h1000_0000),
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_pixel_valid,
    input  logic [CORD_WIDTH-1:0]          i_pixel_x,
    input  logic [CORD_WIDTH-1:0]          i_pixel_y,
    input  logic [VEC_SIZE*DATA_WIDTH-1:0] i_pixel_color,
    output logic                           o_mem_req_valid,
    input  logic                           i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic [31:0]                    o_mem_wdata,
    output logic [3:0]                     o_mem_wstrb,
    output logic                           o_almost_full,
    output logic                           o_overflow,
    input  logic                           i_clear_status,
    output logic [31:0]                    o_written_count,
    output logic [15:0]                    o_clipped_count,
    output logic [15:0]                    o_dropped_count,
    output logic                           o_idle
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_WIDTH + 32;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(FIFO_DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] FBW = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] FBH = ADDR_WIDTH'(FB_HEIGHT);

    logic [ADDR_WIDTH-1:0] x_ext, y_ext, pix_addr;
    logic [31:0]           packed_color;
    logic                  clipped, pixel_ok, push, pop, drop, accept;
    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr, count;
    logic                  fifo_empty, fifo_full;
    logic                  req_valid;

    // Coordinates are signed: the MSB alone marks a negative (off-screen) value.
    assign x_ext   = ADDR_WIDTH'(i_pixel_x);
    assign y_ext   = ADDR_WIDTH'(i_pixel_y);
    assign clipped = i_pixel_x[CORD_WIDTH-1] || i_pixel_y[CORD_WIDTH-1] ||
                     (x_ext >= FBW) || (y_ext >= FBH);
    assign pix_addr = FB_BASE + ((y_ext * FBW + x_ext) << 2);

    always_comb begin
        packed_color = '0;
        for (int i = 0; i < 4; i++) begin
            if (i_pixel_color[i*DATA_WIDTH +: DATA_WIDTH] > DATA_WIDTH'(255))
                packed_color[i*8 +: 8] = 8'hFF;
            else
                packed_color[i*8 +: 8] = i_pixel_color[i*DATA_WIDTH +: 8];
        end
    end

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign accept     = req_valid && i_mem_req_ready;
    assign pop        = !fifo_empty && (!req_valid || i_mem_req_ready);
    // A full FIFO still takes a pixel when its head leaves on the same edge.
    assign pixel_ok   = i_pixel_valid && !clipped;
    assign push       = pixel_ok && (!fifo_full || pop);
    assign drop       = pixel_ok && !push;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {pix_addr, packed_color};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (pop) begin
            req_valid                 <= 1'b1;
            {o_mem_addr, o_mem_wdata} <= fifo_mem[rd_ptr[PTR_W-1:0]];
        end else if (i_mem_req_ready) begin
            req_valid <= 1'b0;
        end
    end

    // Status clear overrides any increment arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_written_count <= '0;
            o_clipped_count <= '0;
            o_dropped_count <= '0;
            o_overflow      <= 1'b0;
        end else if (i_clear_status) begin
            o_written_count <= '0;
            o_clipped_count <= '0;
            o_dropped_count <= '0;
            o_overflow      <= 1'b0;
        end else begin
            if (accept)
                o_written_count <= o_written_count + 32'd1;
            if (i_pixel_valid && clipped && (o_clipped_count != 16'hFFFF))
                o_clipped_count <= o_clipped_count + 16'd1;
            if (drop && (o_dropped_count != 16'hFFFF))
                o_dropped_count <= o_dropped_count + 16'd1;
            if (drop)
                o_overflow <= 1'b1;
        end
    end

    assign o_mem_req_valid = req_valid;
    assign o_mem_wstrb     = req_valid ? 4'hF : 4'h0;
    assign o_almost_full   = (count >= AF_C);
    assign o_idle          = fifo_empty && !req_valid;

endmodule
